// File: rtl/constraint_eval_sched.sv
// Shared evaluator for |((a / DIVISOR) * MULT) terms: round-robin arbitration
// over N requesters feeding one iterative restoring divider.
module constraint_eval_sched #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 15,
  parameter int MULT    = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*WIDTH-1:0]     req_data,
  output logic [N-1:0]           req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [WIDTH-1:0]       rsp_quot,
  output logic                   rsp_result,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; requesters hold valid/data until accepted, the response is held
  // stable while rsp_valid=1 and rsp_ready=0.

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MULT_W = WIDTH'(MULT);
  localparam logic [WIDTH:0]   DIV_W  = (WIDTH+1)'(DIVISOR);

  if (N < 2 || N > 16 || DIVISOR <= 0 || longint'(DIVISOR) >= (longint'(1) << WIDTH) ||
      MULT < 0 || longint'(MULT) >= (longint'(1) << WIDTH)) begin : g_bad_params
    $error("constraint_eval_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_EVAL = 2'd2, S_RESP = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_quot_q, rsp_quot_d;
  logic              rsp_result_q, rsp_result_d;

  logic [WIDTH-1:0]  data_arr [N];
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic              grant_found;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH-1:0]  prod;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Search starts just after the last served requester.
  always_comb begin
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
        grant_data  = data_arr[cand];
      end
    end
  end

  // Gated by rst_n so no grant is advertised while reset is held.
  assign req_ready = (state_q == S_IDLE && grant_found && rst_n) ? (N'(1) << grant_idx) : '0;

  // The stored remainder is always < DIVISOR, so the shift drops only a zero.
  assign rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, a_q[cnt_q]};
  assign prod      = quot_q * MULT_W;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_quot_d   = rsp_quot_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          a_d      = grant_data;
          id_d     = grant_idx;
          rr_ptr_d = grant_idx;
          rem_d    = '0;
          quot_d   = '0;
          cnt_d    = CNT_W'(WIDTH-1);
          state_d  = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_shift >= DIV_W) begin
          rem_d         = rem_shift - DIV_W;
          quot_d[cnt_q] = 1'b1;
        end else begin
          rem_d = rem_shift;
        end
        if (cnt_q == '0) state_d = S_EVAL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_EVAL: begin
        rsp_quot_d   = quot_q;
        rsp_result_d = |prod;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= ID_W'(N-1);
      id_q         <= '0;
      a_q          <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_quot_q   <= '0;
      rsp_result_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_quot   = rsp_quot_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_constraint_eval_sched.sv
// Bench for constraint_eval_sched: a MULT=7 and a MULT=16 instance share the
// same stimulus; vectors carry the expected result for both multipliers.
module tb_constraint_eval_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        rsp_ready;

  logic [3:0]  req_ready, b_req_ready;
  logic        rsp_valid, b_rsp_valid;
  logic [1:0]  rsp_id, b_rsp_id;
  logic [7:0]  rsp_quot, b_rsp_quot;
  logic        rsp_result, b_rsp_result;
  logic        busy, b_busy;
  logic [1:0]  dbg_state, b_dbg_state;

  int checks = 0;
  int errors = 0;

  constraint_eval_sched #(.N(4), .WIDTH(8), .DIVISOR(15), .MULT(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_result(rsp_result),
    .busy(busy), .dbg_state(dbg_state)
  );

  constraint_eval_sched #(.N(4), .WIDTH(8), .DIVISOR(15), .MULT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(b_rsp_id), .rsp_quot(b_rsp_quot), .rsp_result(b_rsp_result),
    .busy(b_busy), .dbg_state(b_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] q;
    logic       r7;
    logic       r16;
  } vec_t;

  vec_t vecs [8];

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_single(input vec_t v);
    int lat;
    @(negedge clk);
    req_valid = 4'b0001 << v.id;
    req_data[v.id*8 +: 8] = v.a;
    rsp_ready = 1'b1;
    #1;
    chk("grant", {28'd0, req_ready}, {28'd0, 4'b0001 << v.id});
    chk("grant_m16", {28'd0, b_req_ready}, {28'd0, 4'b0001 << v.id});
    @(negedge clk);
    req_valid = 4'b0000;
    chk("grant_one_cycle", {28'd0, req_ready}, 32'd0);
    chk("busy_div", {31'd0, busy}, 32'd1);
    wait_rsp(lat);
    chk("latency", lat, 9);
    chk("rsp_id", {30'd0, rsp_id}, v.id);
    chk("rsp_quot", {24'd0, rsp_quot}, {24'd0, v.q});
    chk("rsp_result", {31'd0, rsp_result}, {31'd0, v.r7});
    chk("rsp_quot_m16", {24'd0, b_rsp_quot}, {24'd0, v.q});
    chk("rsp_result_m16", {31'd0, b_rsp_result}, {31'd0, v.r16});
    @(negedge clk);
    chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int seen;

    vecs[0] = '{2,   8'd14, 8'd0,  1'b0, 1'b0};
    vecs[1] = '{0,   8'd15, 8'd1,  1'b1, 1'b1};
    vecs[2] = '{0,  8'd255, 8'd17, 1'b1, 1'b1};
    vecs[3] = '{1,    8'd0, 8'd0,  1'b0, 1'b0};
    vecs[4] = '{3,   8'd29, 8'd1,  1'b1, 1'b1};
    vecs[5] = '{2,  8'd150, 8'd10, 1'b1, 1'b1};
    vecs[6] = '{1,  8'd240, 8'd16, 1'b1, 1'b0};
    vecs[7] = '{3,  8'd225, 8'd15, 1'b1, 1'b1};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("reset_rsp_quot", {24'd0, rsp_quot}, 32'd0);
    chk("reset_rsp_result", {31'd0, rsp_result}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) run_single(vecs[i]);

    // Round robin with all four requesters held valid; last served was 3.
    @(negedge clk);
    req_data  = {8'd75, 8'd60, 8'd45, 8'd30};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      #1;
      while (req_ready == 4'b0000 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << (i % 4)});
      @(negedge clk);
      if (i == 4) req_valid = 4'b0000;
      chk("rr_grant_one_cycle", {28'd0, req_ready}, 32'd0);
      wait_rsp(lat);
      chk("rr_rsp_id", {30'd0, rsp_id}, i % 4);
      chk("rr_rsp_quot", {24'd0, rsp_quot}, (i % 4) + 2);
    end
    @(negedge clk);

    // Backpressure: response held while requester 3 waits.
    @(negedge clk);
    req_data[15:8] = 8'd45;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_data[31:24] = 8'd75;
    req_valid = 4'b1000;
    wait_rsp(lat);
    chk("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_hold_quot", {24'd0, rsp_quot}, 32'd3);
      chk("bp_hold_result", {31'd0, rsp_result}, 32'd1);
      chk("bp_no_grant", {28'd0, req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle", {31'd0, busy}, 32'd0);
    chk("bp_next_grant", {28'd0, req_ready}, 32'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp(lat);
    chk("bp_next_id", {30'd0, rsp_id}, 32'd3);
    chk("bp_next_quot", {24'd0, rsp_quot}, 32'd5);
    @(negedge clk);

    // Reset during the 4th DIV cycle of requester 2's operation.
    @(negedge clk);
    req_data[23:16] = 8'd200;
    req_data[7:0]   = 8'd90;
    req_valid = 4'b0100;
    #1;
    chk("abort_grant", {28'd0, req_ready}, 32'h4);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_div", {30'd0, dbg_state}, 32'd1);
    req_valid = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_first_grant", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp(lat);
    chk("abort_latency", lat, 9);
    chk("abort_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("abort_rsp_quot", {24'd0, rsp_quot}, 32'd6);
    chk("abort_rsp_result", {31'd0, rsp_result}, 32'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("abort_no_extra_rsp", seen, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
